cpu_seq_core: RTL and testbench
===============================

// Module: cpu_seq_core
// PURPOSE
//  Parametrised, clocked successor to the combinational A/B/C/D datapath: a multi-cycle core that owns its
//  register file (A,B,C,D,carry), a PC, instruction fetch over a req/ack bus and a valid/ready output port.
//  Instruction = {op[3:0], imm[DATA_W-1:0]}. Top-level CPU instantiates it between instruction ROM and I/O.
// PARAMETERS
//  DATA_W  8  register/ALU/immediate width (>=4)
//  PC_W    8  program counter width; program space 2**PC_W words, PC wraps modulo 2**PC_W
// PORTS
//  clk         in   1            single clock, rising edge
//  rst_n       in   1            asynchronous, active-low reset
//  imem_req    out  1            fetch request, held until imem_ack
//  imem_addr   out  PC_W         fetch address (=PC), stable while imem_req
//  imem_ack    in   1            instruction valid this cycle
//  imem_data   in   4+DATA_W     {op, imm}, sampled when imem_req&imem_ack
//  in_data     in   DATA_W       input port, sampled in EXEC of IN ops
//  out_valid   out  1            out_data valid; held until out_ready
//  out_ready   in   1            consumer accepts out_data
//  out_data    out  DATA_W       output port value (=B at issue)
//  c_reg,d_reg out  DATA_W each  architectural C and D registers (status/debug)
//  halted      out  1            core stopped by HLT
// BEHAVIOUR
//  - Reset (async assert, sync release): A=B=C=D=0, carry=0, PC=0, state=FETCH, imem_req=0, out_valid=0, halted=0.
//  - FSM: FETCH -> (req=1) WAIT -> on ack latch IR -> EXEC -> FETCH; EXEC of OUT -> OUTW until out_ready; HLT -> HALT (terminal until reset).
//  - imem_req rises the cycle after entering FETCH; ack in same cycle as req is legal; min 3 cycles/instruction.
//  - PC increments by 1 (wrap) in EXEC unless a jump is taken; OUT increments PC on leaving OUTW.
//  - Opcodes: 0 ADD A,imm | 1 MOV A,B | 2 IN A | 3 MOV A,imm | 4 MOV B,A | 5 ADD B,imm | 6 IN B | 7 MOV B,imm
//    8 MOV C,A | 9 MOV D,A | A SUB A,B | B OUT B | C AND A,B | D HLT | E JNC imm | F JMP imm.
//  - Arithmetic: ADD {carry,dst}=dst+imm (DATA_W+1 bits); SUB {borrow}: A=A-B, carry=1 iff A<B (unsigned); AND clears carry.
//    All other ops leave carry unchanged. Jump target = imm[PC_W-1:0] (zero-extended if PC_W>DATA_W).
//  - JNC: taken iff carry==0; carry not modified.
//  - OUT: out_data<=B and out_valid<=1 on entering OUTW; transfer when out_valid&out_ready; out_valid drops next cycle.
//  - No new fetch while out_valid=1; imem_ack while imem_req=0 is ignored.
//  - Reset mid-fetch or mid-OUT: req/valid drop immediately (async); no partial commit.
// CONFIGURATION
//  CPU_STEP_EN defined: adds input step (1b); FSM waits in FETCH until a step pulse, one instruction per pulse;
//    pulses arriving during WAIT/EXEC/OUTW are dropped. Undefined: free-running, no step port.
// STRUCTURE
//  cpu_pkg: opcode localparams (OP_ADD_A..OP_JMP), FSM state encodings (S_FETCH,S_WAIT,S_EXEC,S_OUTW,S_HALT).
//  Sub-module cpu_alu (combinational: a, b, op -> y, carry_out); register file, PC, FSM stay in cpu_seq_core.
// TESTING
//  1 Reset, prog {3:MOV A,0x05; 0:ADD A,0x03; 9:MOV D,A; D:HLT} -> d_reg=0x08, carry=0, halted=1, PC=3.
//  2 MOV A,0xFF; ADD A,0x02; JNC 0x10 -> A=0x01, carry=1, jump not taken, next fetch addr 0x03.
//  3 MOV B,0x2A; OUT B with out_ready low 5 cycles -> out_valid held, out_data=0x2A, no imem_req until accept.
//  4 JMP 0xFF with PC_W=8 then fall-through -> fetch 0xFF, next fetch 0x00 (wrap).
//  5 imem_ack delayed 0/1/4 cycles; rst_n pulsed low during WAIT -> imem_req=0 at once, refetch from 0x00.
//  6 CPU_STEP_EN: 3 step pulses -> exactly 3 instructions retire; DATA_W=16 rerun of test 1 -> D=0x0008.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the sequential A/B/C/D core.
//   - OP_* : 4-bit opcodes, instruction = {op, imm}
//   - state_e : core FSM states
package cpu_pkg;

  localparam logic [3:0] OP_ADD_A  = 4'h0;
  localparam logic [3:0] OP_MOV_AB = 4'h1;
  localparam logic [3:0] OP_IN_A   = 4'h2;
  localparam logic [3:0] OP_MOV_AI = 4'h3;
  localparam logic [3:0] OP_MOV_BA = 4'h4;
  localparam logic [3:0] OP_ADD_B  = 4'h5;
  localparam logic [3:0] OP_IN_B   = 4'h6;
  localparam logic [3:0] OP_MOV_BI = 4'h7;
  localparam logic [3:0] OP_MOV_CA = 4'h8;
  localparam logic [3:0] OP_MOV_DA = 4'h9;
  localparam logic [3:0] OP_SUB    = 4'hA;
  localparam logic [3:0] OP_OUT    = 4'hB;
  localparam logic [3:0] OP_AND    = 4'hC;
  localparam logic [3:0] OP_HLT    = 4'hD;
  localparam logic [3:0] OP_JNC    = 4'hE;
  localparam logic [3:0] OP_JMP    = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_WAIT  = 3'd1,
    S_EXEC  = 3'd2,
    S_OUTW  = 3'd3,
    S_HALT  = 3'd4
  } state_e;

endpackage

// File: rtl/cpu_seq_core_if.sv
// cpu_seq_core_if: instruction-fetch (req/ack) and output-port (valid/ready) buses.
//   imem_req/imem_addr   core -> memory, request held until imem_ack
//   imem_ack/imem_data   memory -> core, {op, imm}
//   out_valid/out_data   core -> consumer, held until out_ready
//   out_ready            consumer -> core
// master = core side, slave = memory/consumer side.
interface cpu_seq_core_if #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8
);
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_ack;
  logic [DATA_W+3:0] imem_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output imem_req, imem_addr, out_valid, out_data,
    input  imem_ack, imem_data, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_data,
    output imem_ack, imem_data, out_ready
  );
endinterface

// File: rtl/cpu_alu.sv
// cpu_alu: combinational ALU for the core.
//   a, b   : operands (core selects A/B/imm)
//   op     : current opcode
//   cin    : current carry, passed through for ops that keep it
//   y      : result, carry_out : next carry
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   op,
  input  logic         cin,
  output logic [W-1:0] y,
  output logic         carry_out
);
  logic [W:0] sum;

  always_comb begin
    sum       = {1'b0, a} + {1'b0, b};
    y         = b;
    carry_out = cin;
    case (op)
      OP_ADD_A, OP_ADD_B: begin
        y         = sum[W-1:0];
        carry_out = sum[W];
      end
      OP_SUB: begin
        y         = a - b;
        carry_out = (a < b);   // borrow
      end
      OP_AND: begin
        y         = a & b;
        carry_out = 1'b0;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/cpu_seq_core.sv
// cpu_seq_core: multi-cycle A/B/C/D core with PC, req/ack instruction fetch
// and a valid/ready output port.
//   clk, rst_n  : clock, async active-low reset
//   step        : (CPU_STEP_EN only) one instruction per pulse seen in FETCH
//   bus         : cpu_seq_core_if.master (fetch + output port)
//   in_data     : input port, sampled in EXEC of IN ops
//   c_reg,d_reg : architectural C/D registers
//   halted      : core stopped by HLT until reset
// Optional feature macro: CPU_STEP_EN (single-step gating of FETCH).
module cpu_seq_core
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef CPU_STEP_EN
  input  logic              step,
`endif
  cpu_seq_core_if.master    bus,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] c_reg,
  output logic [DATA_W-1:0] d_reg,
  output logic              halted
);
  state_e            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic              carry_q, carry_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W+3:0] ir_q, ir_d;
  logic              req_q, req_d, ovld_q, ovld_d;
  logic [DATA_W-1:0] odata_q, odata_d;

  logic [3:0]        op;
  logic [DATA_W-1:0] imm, alu_a, alu_b, alu_y;
  logic              alu_c, go;
  logic [PC_W-1:0]   pc_inc, jtgt;

  assign op     = ir_q[DATA_W+3:DATA_W];
  assign imm    = ir_q[DATA_W-1:0];
  assign pc_inc = pc_q + 1'b1;
  assign jtgt   = PC_W'(imm);   // truncates or zero-extends to PC width

`ifdef CPU_STEP_EN
  assign go = step;
`else
  assign go = 1'b1;
`endif

  assign alu_a = (op == OP_ADD_B) ? b_q : a_q;
  assign alu_b = (op == OP_ADD_A || op == OP_ADD_B) ? imm : b_q;

  cpu_alu #(.W(DATA_W)) u_alu (
    .a(alu_a), .b(alu_b), .op(op), .cin(carry_q), .y(alu_y), .carry_out(alu_c)
  );

  always_comb begin
    state_d = state_q;
    a_d = a_q; b_d = b_q; c_d = c_q; d_d = d_q;
    carry_d = carry_q; pc_d = pc_q; ir_d = ir_q;
    req_d = req_q; ovld_d = ovld_q; odata_d = odata_q;
    case (state_q)
      S_FETCH: if (go) begin
        req_d   = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: if (bus.imem_ack) begin
        ir_d    = bus.imem_data;
        req_d   = 1'b0;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        pc_d    = pc_inc;
        state_d = S_FETCH;
        case (op)
          OP_ADD_A, OP_SUB, OP_AND: begin a_d = alu_y; carry_d = alu_c; end
          OP_MOV_AB: a_d = b_q;
          OP_IN_A:   a_d = in_data;
          OP_MOV_AI: a_d = imm;
          OP_MOV_BA: b_d = a_q;
          OP_ADD_B:  begin b_d = alu_y; carry_d = alu_c; end
          OP_IN_B:   b_d = in_data;
          OP_MOV_BI: b_d = imm;
          OP_MOV_CA: c_d = a_q;
          OP_MOV_DA: d_d = a_q;
          OP_OUT: begin
            // PC advances only once the consumer takes the value
            pc_d    = pc_q;
            odata_d = b_q;
            ovld_d  = 1'b1;
            state_d = S_OUTW;
          end
          OP_HLT: begin
            pc_d    = pc_q;
            state_d = S_HALT;
          end
          OP_JNC: if (!carry_q) pc_d = jtgt;
          OP_JMP: pc_d = jtgt;
          default: ;
        endcase
      end
      S_OUTW: if (bus.out_ready) begin
        ovld_d  = 1'b0;
        pc_d    = pc_inc;
        state_d = S_FETCH;
      end
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      a_q <= '0; b_q <= '0; c_q <= '0; d_q <= '0;
      carry_q <= 1'b0; pc_q <= '0; ir_q <= '0;
      req_q <= 1'b0; ovld_q <= 1'b0; odata_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d; b_q <= b_d; c_q <= c_d; d_q <= d_d;
      carry_q <= carry_d; pc_q <= pc_d; ir_q <= ir_d;
      req_q <= req_d; ovld_q <= ovld_d; odata_q <= odata_d;
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = pc_q;
  assign bus.out_valid = ovld_q;
  assign bus.out_data  = odata_q;
  assign c_reg         = c_q;
  assign d_reg         = d_q;
  assign halted        = (state_q == S_HALT);
endmodule

// File: tb/tb_cpu_seq_core.sv
// tb_cpu_seq_core: randomized + directed bench with an instruction-level
// reference model. A second DATA_W=16 instance runs a fixed program.
module tb_cpu_seq_core;
  localparam int DW = 8;
  localparam int PW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cpu_seq_core_if #(.DATA_W(DW), .PC_W(PW)) bus ();
  logic [DW-1:0] in_data, c_reg, d_reg;
  logic          halted;

  cpu_seq_core_if #(.DATA_W(16), .PC_W(PW)) bus16 ();
  logic [15:0] in16, c16, d16;
  logic        halted16;

`ifdef CPU_STEP_EN
  logic step;
  initial step = 1'b1;
`endif

  cpu_seq_core #(.DATA_W(DW), .PC_W(PW)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef CPU_STEP_EN
    .step(step),
`endif
    .bus(bus), .in_data(in_data), .c_reg(c_reg), .d_reg(d_reg), .halted(halted)
  );

  cpu_seq_core #(.DATA_W(16), .PC_W(PW)) dut16 (
    .clk(clk), .rst_n(rst_n),
`ifdef CPU_STEP_EN
    .step(step),
`endif
    .bus(bus16), .in_data(in16), .c_reg(c16), .d_reg(d16), .halted(halted16)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---------------- program memory + reference model state -------------
  logic [DW+3:0] mem [0:255];
  logic [DW-1:0] m_a, m_b, m_c, m_d, m_out;
  logic          m_carry, m_halt;
  logic [PW-1:0] m_pc;
  int            retired, out_acc;
  bit            pend, want_vld, want_drop, want_halt, run_en;
  logic [DW+3:0] pend_ins;
  logic [PW-1:0] fetch_log [$];
  bit            force_rdy_low = 0;
  int            force_dly = -1;

  function automatic logic [DW+3:0] ins(input logic [3:0] op, input logic [DW-1:0] imm);
    return {op, imm};
  endfunction

  task automatic fill_hlt();
    for (int i = 0; i < 256; i++) mem[i] = ins(4'hD, 8'h00);
  endtask

  // Instruction-level semantics of one retired instruction.
  task automatic exec(input logic [DW+3:0] w, input logic [DW-1:0] inp);
    logic [3:0]    op;
    logic [DW-1:0] imm;
    logic [PW-1:0] nxt;
    int unsigned   s;
    op  = w[DW+3:DW];
    imm = w[DW-1:0];
    nxt = m_pc + 8'd1;
    retired++;
    case (op)
      4'h0: begin s = 32'(m_a) + 32'(imm); m_a = s[DW-1:0]; m_carry = s[DW]; end
      4'h1: m_a = m_b;
      4'h2: m_a = inp;
      4'h3: m_a = imm;
      4'h4: m_b = m_a;
      4'h5: begin s = 32'(m_b) + 32'(imm); m_b = s[DW-1:0]; m_carry = s[DW]; end
      4'h6: m_b = inp;
      4'h7: m_b = imm;
      4'h8: m_c = m_a;
      4'h9: m_d = m_a;
      4'hA: begin m_carry = (m_a < m_b); m_a = m_a - m_b; end
      4'hB: begin m_out = m_b; want_vld = 1; end
      4'hC: begin m_a = m_a & m_b; m_carry = 1'b0; end
      4'hD: begin m_halt = 1; want_halt = 1; nxt = m_pc; end
      4'hE: if (!m_carry) nxt = imm;
      default: nxt = imm;
    endcase
    m_pc = nxt;
  endtask

  // ---------------- compare process (every negedge) ---------------------
  initial begin
    forever begin
      @(negedge clk);
      if (run_en && rst_n) begin
        if (want_vld)  begin chk("out_valid_rise", bus.out_valid, 1); want_vld = 0; end
        if (want_drop) begin chk("out_valid_drop", bus.out_valid, 0); want_drop = 0; end
        if (want_halt) begin chk("halted", halted, 1); chk("halt_no_req", bus.imem_req, 0); end
        if (bus.imem_req) begin
          chk("fetch_addr", bus.imem_addr, m_pc);
          chk("c_reg", c_reg, m_c);
          chk("d_reg", d_reg, m_d);
          chk("run_not_halted", halted, 0);
          chk("req_no_valid", bus.out_valid, 0);
        end
        if (bus.out_valid) begin
          chk("out_data", bus.out_data, m_out);
          chk("valid_no_req", bus.imem_req, 0);
          if (bus.out_ready) begin want_drop = 1; out_acc++; end
        end
        if (pend) begin exec(pend_ins, in_data); pend = 0; end
        if (bus.imem_req && bus.imem_ack) begin
          pend     = 1;
          pend_ins = mem[bus.imem_addr];
          fetch_log.push_back(bus.imem_addr);
        end
      end
    end
  end

  // ---------------- memory / consumer / input responder -----------------
  initial begin
    int wait_cnt, cur_dly;
    wait_cnt = 0; cur_dly = 0;
    bus.imem_ack = 0; bus.imem_data = '0; bus.out_ready = 0; in_data = '0;
    forever begin
      @(posedge clk); #1;
      in_data = DW'($urandom);
      bus.imem_ack = 0;
      if (bus.imem_req) begin
        if (wait_cnt >= cur_dly) begin
          bus.imem_ack  = 1;
          bus.imem_data = mem[bus.imem_addr];
        end
        wait_cnt++;
      end else begin
        wait_cnt = 0;
        case ($urandom_range(0, 2))
          0: cur_dly = 0;
          1: cur_dly = 1;
          default: cur_dly = 4;
        endcase
        if (force_dly >= 0) cur_dly = force_dly;
        bus.imem_data = 12'($urandom);
        if ($urandom_range(0, 7) == 0) bus.imem_ack = 1;   // stray ack, must be ignored
      end
      bus.out_ready = force_rdy_low ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  // DATA_W=16 instance: zero-wait memory with a fixed program.
  function automatic logic [19:0] rom16(input logic [PW-1:0] a);
    case (a)
      8'd0:    return {4'h3, 16'h0005};
      8'd1:    return {4'h0, 16'h0003};
      8'd2:    return {4'h9, 16'h0000};
      default: return {4'hD, 16'h0000};
    endcase
  endfunction

  initial begin
    bus16.imem_ack = 0; bus16.imem_data = '0; bus16.out_ready = 1; in16 = '0;
    forever begin
      @(posedge clk); #1;
      bus16.imem_ack  = bus16.imem_req;
      bus16.imem_data = rom16(bus16.imem_addr);
    end
  end

  // ---------------- sequencing helpers ----------------------------------
  task automatic do_reset();
    run_en = 0;
    rst_n  = 0;
    #1;
    chk("rst_req", bus.imem_req, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_c", c_reg, 0);
    chk("rst_d", d_reg, 0);
    m_a = 0; m_b = 0; m_c = 0; m_d = 0; m_out = 0; m_carry = 0; m_pc = 0; m_halt = 0;
    retired = 0; out_acc = 0;
    pend = 0; want_vld = 0; want_drop = 0; want_halt = 0;
    fetch_log.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("first_cycle_no_req", bus.imem_req, 0);
    run_en = 1;
  endtask

  task automatic run(input int max_ret, input int max_cyc, input bit exp_halt);
    int cyc;
    cyc = 0;
    while (!m_halt && retired < max_ret && cyc < max_cyc) begin
      @(posedge clk);
      cyc++;
    end
    repeat (3) @(posedge clk);
    if (exp_halt) chk("halt_reached", m_halt, 1);
  endtask

  task automatic load_t1();
    fill_hlt();
    mem[0] = ins(4'h3, 8'h05);
    mem[1] = ins(4'h0, 8'h03);
    mem[2] = ins(4'h9, 8'h00);
    mem[3] = ins(4'hD, 8'h00);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main ------------------------------------------------
  initial begin
    int n;
    rst_n = 0;
    run_en = 0;

    // T1: MOV A,5; ADD A,3; MOV D,A; HLT
    load_t1();
    do_reset();
    run(50, 300, 1);
    chk("t1_d_reg", d_reg, 8'h08);
    chk("t1_halted", halted, 1);
    chk("t1_model_d", m_d, 8'h08);
    chk("t1_model_carry", m_carry, 0);
    chk("t1_model_pc", m_pc, 8'h03);
    chk("t1_last_fetch", fetch_log[fetch_log.size()-1], 8'h03);
    chk("t1_d16", d16, 16'h0008);
    chk("t1_halted16", halted16, 1);

    // T2: carry set -> JNC not taken
    fill_hlt();
    mem[0] = ins(4'h3, 8'hFF);
    mem[1] = ins(4'h0, 8'h02);
    mem[2] = ins(4'hE, 8'h10);
    mem[3] = ins(4'h8, 8'h00);
    do_reset();
    run(50, 300, 1);
    chk("t2_c_reg", c_reg, 8'h01);
    chk("t2_model_carry", m_carry, 1);
    chk("t2_nofetch", fetch_log.size() >= 4, 1);
    if (fetch_log.size() >= 4) chk("t2_fetch3", fetch_log[3], 8'h03);

    // T2b: carry clear -> JNC taken
    fill_hlt();
    mem[0]    = ins(4'h3, 8'h01);
    mem[1]    = ins(4'h0, 8'h02);
    mem[2]    = ins(4'hE, 8'h10);
    mem[8'h10] = ins(4'h9, 8'h00);
    do_reset();
    run(50, 300, 1);
    chk("t2b_d_reg", d_reg, 8'h03);
    if (fetch_log.size() >= 4) chk("t2b_fetch3", fetch_log[3], 8'h10);
    else chk("t2b_nfetch", fetch_log.size(), 4);

    // T3: OUT with consumer stalled 5 cycles
    fill_hlt();
    mem[0] = ins(4'h7, 8'h2A);
    mem[1] = ins(4'hB, 8'h00);
    force_rdy_low = 1;
    do_reset();
    n = 0;
    while (!bus.out_valid && n < 60) begin @(negedge clk); n++; end
    chk("t3_valid_seen", bus.out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_held", bus.out_valid, 1);
      chk("t3_data", bus.out_data, 8'h2A);
      chk("t3_no_req", bus.imem_req, 0);
    end
    force_rdy_low = 0;
    run(50, 300, 1);
    chk("t3_accepted", out_acc, 1);
    chk("t3_model_pc", m_pc, 8'h02);

    // T4: JMP 0xFF, fall through wraps to 0x00
    fill_hlt();
    mem[0]     = ins(4'hF, 8'hFF);
    mem[8'hFF] = ins(4'h3, 8'h07);
    do_reset();
    run(3, 300, 0);
    chk("t4_nfetch", fetch_log.size() >= 3, 1);
    if (fetch_log.size() >= 3) begin
      chk("t4_fetch1", fetch_log[1], 8'hFF);
      chk("t4_fetch2", fetch_log[2], 8'h00);
    end

    // T5: reset while waiting for a slow ack, then refetch from 0
    load_t1();
    force_dly = 6;
    do_reset();
    n = 0;
    while (!bus.imem_req && n < 20) begin @(negedge clk); n++; end
    chk("t5_req_up", bus.imem_req, 1);
    @(negedge clk); #2;
    force_dly = -1;
    do_reset();
    run(50, 300, 1);
    chk("t5_first_fetch", fetch_log[0], 8'h00);
    chk("t5_d_reg", d_reg, 8'h08);

    // Random programs, random ack/ready timing, reset at arbitrary points
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < 256; i++) mem[i] = 12'($urandom);
      @(posedge clk); #($urandom_range(1, 4));
      do_reset();
      run(60, 1500, 0);
    end

    run_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
